// File: rtl/tl_reg_bridge.sv
// TileLink-UL style request/response bridge onto a simple register-file port.
// Requests flow through a fixed-length delay line into an in-order response FIFO.
module tl_reg_bridge #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int IW     = 2,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [3:0]      a_opcode,
  input  logic [DW/8-1:0] a_mask,
  input  logic [AW-1:0]   a_address,
  input  logic [IW-1:0]   a_source,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            d_ready,
  output logic            d_valid,
  output logic [3:0]      d_opcode,
  output logic [IW-1:0]   d_source,
  output logic            d_error,
  output logic [DW-1:0]   d_data,
  output logic            reg_wr,
  output logic            reg_rd,
  output logic [DW/8-1:0] reg_byte,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  input  logic [DW-1:0]   reg_rdata
);
  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int NS = RD_LAT + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  typedef enum logic [1:0] {K_PUT = 2'd0, K_GET = 2'd1, K_ILL = 2'd2} kind_e;

  kind_e           a_kind;
  logic            accept, push, pop;
  logic            a_ready_q, a_ready_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
  logic [BW-1:0]   reg_byte_q, reg_byte_d;
  logic [AW-1:0]   reg_addr_q, reg_addr_d;
  logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
  logic            dl_vld_q [NS];
  logic            dl_vld_d [NS];
  kind_e           dl_kind_q [NS];
  kind_e           dl_kind_d [NS];
  logic [IW-1:0]   dl_src_q [NS];
  logic [IW-1:0]   dl_src_d [NS];
  logic [3:0]      mem_op   [DEPTH];
  logic            mem_err  [DEPTH];
  logic [IW-1:0]   mem_src  [DEPTH];
  logic [DW-1:0]   mem_data [DEPTH];
  logic [PW-2:0]   rd_idx;

  always_comb begin
    a_kind = K_ILL;
    case (a_opcode)
      4'd0, 4'd1: a_kind = K_PUT;
      4'd4:       a_kind = K_GET;
      default:    a_kind = K_ILL;
    endcase
  end

  assign accept = a_valid && a_ready_q;
  assign push   = dl_vld_q[RD_LAT];
  assign pop    = d_valid && d_ready;

  // Register strobe for the cycle following acceptance; illegal opcodes never touch the file.
  always_comb begin
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_byte_d  = '0;
    reg_addr_d  = '0;
    reg_wdata_d = '0;
    if (accept && a_kind != K_ILL) begin
      reg_wr_d    = (a_kind == K_PUT);
      reg_rd_d    = (a_kind == K_GET);
      reg_addr_d  = a_address;
      reg_byte_d  = (a_opcode == 4'd0) ? '1 : a_mask;
      reg_wdata_d = (a_kind == K_PUT) ? a_data : '0;
    end
  end

  always_comb begin
    dl_vld_d[0]  = accept;
    dl_kind_d[0] = a_kind;
    dl_src_d[0]  = a_source;
    for (int i = 1; i < NS; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_kind_d[i] = dl_kind_q[i-1];
      dl_src_d[i]  = dl_src_q[i-1];
    end
  end

  // Occupancy covers both the delay line and the FIFO, so the FIFO can never overflow.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    occ_d     = occ_q + OW'(accept) - OW'(pop);
    a_ready_d = (occ_d < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ready_q   <= 1'b0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_byte_q  <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      for (int i = 0; i < NS; i++) begin
        dl_vld_q[i]  <= 1'b0;
        dl_kind_q[i] <= K_PUT;
        dl_src_q[i]  <= '0;
      end
    end else begin
      a_ready_q   <= a_ready_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_byte_q  <= reg_byte_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      for (int i = 0; i < NS; i++) begin
        dl_vld_q[i]  <= dl_vld_d[i];
        dl_kind_q[i] <= dl_kind_d[i];
        dl_src_q[i]  <= dl_src_d[i];
      end
    end
  end

  // Read data is captured on the same edge the matching request leaves the delay line.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr_q[PW-2:0]]   <= (dl_kind_q[RD_LAT] == K_GET) ? 4'd1 : 4'd0;
      mem_err[wr_ptr_q[PW-2:0]]  <= (dl_kind_q[RD_LAT] == K_ILL);
      mem_src[wr_ptr_q[PW-2:0]]  <= dl_src_q[RD_LAT];
      mem_data[wr_ptr_q[PW-2:0]] <= (dl_kind_q[RD_LAT] == K_GET) ? reg_rdata : '0;
    end
  end

  assign rd_idx    = rd_ptr_q[PW-2:0];
  assign d_valid   = (wr_ptr_q != rd_ptr_q);
  assign d_opcode  = d_valid ? mem_op[rd_idx]   : '0;
  assign d_error   = d_valid ? mem_err[rd_idx]  : 1'b0;
  assign d_source  = d_valid ? mem_src[rd_idx]  : '0;
  assign d_data    = d_valid ? mem_data[rd_idx] : '0;

  assign a_ready   = a_ready_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_byte  = reg_byte_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
endmodule
